// File: rtl/xor_gate_unit.sv
// ---------------------------------------------------------------------------
// xor_gate_unit
//
// Registered, width-parameterised bitwise XOR stage. Each accepted operand
// pair produces out = in1 ^ in2 one clock later, together with the parity,
// popcount and nonzero flag of that same XOR result. A saturating counter
// tracks how many accepted samples had in1 != in2.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1)
//   CNT_W  width of the mismatch counter (>= 1)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset, clears every output
//   in1, in2      operands (WIDTH bits)
//   in_valid      operands valid this cycle
//   cnt_clr       synchronous clear of mismatch_cnt (wins over an increment)
//   out           registered in1 ^ in2
//   out_valid     out and the flags carry a fresh result this cycle
//   parity        XOR-reduction of out
//   diff_count    number of 1 bits in out
//   mismatch      out != 0
//   mismatch_cnt  saturating count of accepted mismatching samples
// ---------------------------------------------------------------------------
module xor_gate_unit #(
    parameter  int WIDTH = 1,
    parameter  int CNT_W = 16,
    localparam int DCW   = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             parity,
    output logic [DCW-1:0]   diff_count,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    logic [WIDTH-1:0] w_xor;
    logic [DCW-1:0]   w_pop;
    logic             w_mismatch;
    logic             w_cntSaturated;

    logic [WIDTH-1:0] r_out;
    logic             r_outValid;
    logic             r_parity;
    logic [DCW-1:0]   r_diffCount;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_mismatchCnt;

    assign w_xor          = in1 ^ in2;
    assign w_mismatch     = |w_xor;
    assign w_cntSaturated = &r_mismatchCnt;

    // Population count of the XOR result, computed from the inputs so it
    // can be registered in the same cycle as out.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + DCW'(w_xor[i]);
        end
    end

    // Result register: loads on an accepted sample, otherwise holds the
    // previous result while out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_outValid  <= 1'b0;
            r_parity    <= 1'b0;
            r_diffCount <= '0;
            r_mismatch  <= 1'b0;
        end else begin
            r_outValid <= in_valid;
            if (in_valid) begin
                r_out       <= w_xor;
                r_parity    <= ^w_xor;
                r_diffCount <= w_pop;
                r_mismatch  <= w_mismatch;
            end
        end
    end

    // Mismatch counter: a clear takes priority over a same-cycle increment,
    // and the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatchCnt <= '0;
        end else if (cnt_clr) begin
            r_mismatchCnt <= '0;
        end else if (in_valid && w_mismatch && !w_cntSaturated) begin
            r_mismatchCnt <= r_mismatchCnt + 1'b1;
        end
    end

    assign out          = r_out;
    assign out_valid    = r_outValid;
    assign parity       = r_parity;
    assign diff_count   = r_diffCount;
    assign mismatch     = r_mismatch;
    assign mismatch_cnt = r_mismatchCnt;

endmodule

// File: tb/tb_xor_gate_unit.sv
// ---------------------------------------------------------------------------
// tb_xor_gate_unit
//
// Drives two instances of xor_gate_unit from one clock and reset:
//   u1 : WIDTH=1, CNT_W=16  (truth table, reset behaviour, counting)
//   u8 : WIDTH=8, CNT_W=2   (vectors, flags, valid gating, saturation)
// Expected values come from a behavioural model of the XOR stage built on
// plain arithmetic ($countones, reduction XOR, integer counting with a cap).
// ---------------------------------------------------------------------------
module tb_xor_gate_unit;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, v1, c1;
    logic       o1, ov1, p1, m1;
    logic [0:0] dc1;
    logic [15:0] cnt1;

    logic [7:0] a8, b8;
    logic       v8, c8;
    logic [7:0] o8;
    logic       ov8, p8, m8;
    logic [3:0] dc8;
    logic [1:0] cnt8;

    int checks = 0;
    int errors = 0;

    int eOut1, eVal1, ePar1, eDc1, eMis1, eCnt1;
    int eOut8, eVal8, ePar8, eDc8, eMis8, eCnt8;

    xor_gate_unit #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in1(a1), .in2(b1), .in_valid(v1),
        .cnt_clr(c1), .out(o1), .out_valid(ov1), .parity(p1),
        .diff_count(dc1), .mismatch(m1), .mismatch_cnt(cnt1)
    );

    xor_gate_unit #(.WIDTH(8), .CNT_W(2)) u8 (
        .clk(clk), .rst_n(rst_n), .in1(a8), .in2(b8), .in_valid(v8),
        .cnt_clr(c8), .out(o8), .out_valid(ov8), .parity(p8),
        .diff_count(dc8), .mismatch(m8), .mismatch_cnt(cnt8)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point shared by every check.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model state after reset.
    task automatic resetModel();
        eOut1 = 0; eVal1 = 0; ePar1 = 0; eDc1 = 0; eMis1 = 0; eCnt1 = 0;
        eOut8 = 0; eVal8 = 0; ePar8 = 0; eDc8 = 0; eMis8 = 0; eCnt8 = 0;
    endtask

    // Compare every output of both instances with the model.
    task automatic checkOutput();
        chk("u1.out",          32'(o1),   32'(eOut1));
        chk("u1.out_valid",    32'(ov1),  32'(eVal1));
        chk("u1.parity",       32'(p1),   32'(ePar1));
        chk("u1.diff_count",   32'(dc1),  32'(eDc1));
        chk("u1.mismatch",     32'(m1),   32'(eMis1));
        chk("u1.mismatch_cnt", 32'(cnt1), 32'(eCnt1));
        chk("u8.out",          32'(o8),   32'(eOut8));
        chk("u8.out_valid",    32'(ov8),  32'(eVal8));
        chk("u8.parity",       32'(p8),   32'(ePar8));
        chk("u8.diff_count",   32'(dc8),  32'(eDc8));
        chk("u8.mismatch",     32'(m8),   32'(eMis8));
        chk("u8.mismatch_cnt", 32'(cnt8), 32'(eCnt8));
    endtask

    // Drive one cycle of inputs on the falling edge, advance the model at
    // the rising edge, then sample the DUTs 1 unit later.
    task automatic applyStimulus(
        input logic ia1, input logic ib1, input logic iv1, input logic ic1,
        input logic [7:0] ia8, input logic [7:0] ib8, input logic iv8, input logic ic8
    );
        logic [7:0] x;
        @(negedge clk);
        a1 = ia1; b1 = ib1; v1 = iv1; c1 = ic1;
        a8 = ia8; b8 = ib8; v8 = iv8; c8 = ic8;
        @(posedge clk);
        eVal1 = int'(iv1);
        if (iv1) begin
            eOut1 = int'(ia1 ^ ib1);
            ePar1 = eOut1;
            eDc1  = eOut1;
            eMis1 = int'(ia1 != ib1);
        end
        if (ic1)                                  eCnt1 = 0;
        else if (iv1 && ia1 != ib1 && eCnt1 < 65535) eCnt1 = eCnt1 + 1;
        eVal8 = int'(iv8);
        if (iv8) begin
            x     = ia8 ^ ib8;
            eOut8 = int'(x);
            ePar8 = $countones(x) % 2;
            eDc8  = $countones(x);
            eMis8 = int'(x != 8'h00);
        end
        if (ic8)                                  eCnt8 = 0;
        else if (iv8 && ia8 != ib8 && eCnt8 < 3)  eCnt8 = eCnt8 + 1;
        #1;
        checkOutput();
    endtask

    initial begin
        a1 = 0; b1 = 0; v1 = 0; c1 = 0;
        a8 = 0; b8 = 0; v8 = 0; c8 = 0;
        rst_n = 1'b0;
        resetModel();
        #3;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table on u1; u8 idle.
        applyStimulus(0, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        applyStimulus(0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
        applyStimulus(1, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        applyStimulus(1, 1, 1, 0, 8'h00, 8'h00, 0, 0);
        chk("u1.tt_out_last", 32'(o1),   32'd0);
        chk("u1.tt_cnt_end",  32'(cnt1), 32'd2);

        // 8-bit vectors.
        applyStimulus(0, 0, 0, 0, 8'hF0, 8'hAA, 1, 0);
        chk("u8.vec_out",  32'(o8),  32'h5A);
        chk("u8.vec_dc",   32'(dc8), 32'd4);
        chk("u8.vec_par",  32'(p8),  32'd0);
        chk("u8.vec_mis",  32'(m8),  32'd1);
        applyStimulus(0, 0, 0, 0, 8'h3C, 8'h3C, 1, 0);
        chk("u8.eq_out",   32'(o8),  32'd0);
        chk("u8.eq_mis",   32'(m8),  32'd0);
        chk("u8.eq_dc",    32'(dc8), 32'd0);

        // Valid gating: inputs change while in_valid is low, out holds.
        applyStimulus(1, 0, 1, 0, 8'h81, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(logic'(i[0]), 1'b1, 0, 0, 8'($urandom), 8'($urandom), 0, 0);
            chk("u8.gate_hold", 32'(o8), 32'h81);
        end

        // Saturation on u8 (CNT_W=2): clear, then five mismatches.
        applyStimulus(0, 0, 0, 1, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 8'h01 << i, 8'h00, 1, 0);
            chk("u8.sat_seq", 32'(cnt8), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        applyStimulus(0, 0, 0, 0, 8'hFF, 8'h00, 1, 1);
        chk("u8.clr_wins", 32'(cnt8), 32'd0);

        // Async reset between edges while u1.out = 1.
        applyStimulus(1, 0, 1, 0, 8'h0F, 8'h00, 1, 0);
        @(negedge clk);
        v1 = 1'b0; v8 = 1'b0;
        #1;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput();
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 1, 0, 0, 8'h55, 8'hAA, 0, 0);
        chk("u1.no_pulse_after_rst", 32'(ov1), 32'd0);
        applyStimulus(1, 0, 1, 0, 8'h55, 8'hAA, 1, 0);
        chk("u1.first_after_rst", 32'(o1), 32'd1);
        chk("u8.first_after_rst", 32'(o8), 32'hFF);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0),
                          8'($urandom), ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom),
                          logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
